matmul_feeder: RTL and testbench
================================

# matmul_feeder

Upstream stage of the systolic multiply engine. Accepts one A/B operand pair per job through a valid/ready load port and latches it. It then drives the diagonally skewed edge vectors (`in_a` rows, `in_b` columns) and the `start_bit` pulse into the `MAX_DIM`×`MAX_DIM` PE array. After the last product has been accumulated it pulses `done_o`, which tells the consumer to sample the array's result and overflow outputs.

## Interface
- `DW`, 8, element bit width
- `BW`, 32, accumulator bit width (kept for parity with the array)
- `MAX_DIM`, `BW/DW`, array rows/columns
- `Elements_Num`, `MAX_DIM*MAX_DIM`, elements per matrix
- `CW`, `$clog2(MAX_DIM)`, dimension-field width
- `clk_i`  in  1  clock; single clock domain
- `reset_ni`  in  1  reset; asynchronous, active-low
- `ld_valid_i`  in  1  operand pair valid
- `ld_ready_o`  out  1  feeder can accept a job (IDLE only)
- `mat_a_i`  in  `Elements_Num*DW`  A, row-major; element (r,k) at bits `[(r*MAX_DIM+k)*DW +: DW]`
- `mat_b_i`  in  `Elements_Num*DW`  B, row-major; element (k,c) at bits `[(k*MAX_DIM+c)*DW +: DW]`
- `m_dim_i`, `k_dim_i`, `n_dim_i`  in  `CW` each  dimensions M, K, N encoded as value−1
- `a_vec_o`  out  `MAX_DIM*DW`  to array `in_a`; lane r feeds row r
- `b_vec_o`  out  `MAX_DIM*DW`  to array `in_b`; lane c feeds column c
- `start_bit_o`  out  1  to array `start_bit_i`; one-cycle job-start pulse
- `busy_o`  out  1  job in progress (any state except IDLE)
- `done_o`  out  1  one-cycle pulse; array result valid this cycle

## Operation
- **States:**
  - IDLE → START on a load handshake.
  - START → STREAM after 1 cycle.
  - STREAM → DRAIN after `K+MAX_DIM-1` cycles.
  - DRAIN → DONE after `MAX_DIM-1` cycles.
  - DONE → IDLE after 1 cycle.
- **Load:** on `ld_valid_i & ld_ready_o` at an edge, latch A, B, M, K, N (decoded to 1..`MAX_DIM`). `ld_ready_o` = (state==IDLE). Inputs are ignored in all other states.
- **Step counter:** `t` counts 0..`K+MAX_DIM-2` in STREAM.
- **Lane r of `a_vec_o`:** `A[r][t-r]` if `r<M` and `0 <= t-r < K`; otherwise 0.
- **Lane c of `b_vec_o`:** `B[t-c][c]` if `c<N` and `0 <= t-c < K`; otherwise 0.
- **Zero padding:** padded lanes are exactly 0, so unused PEs accumulate 0 and out-of-range results equal the `in_c` addend.
- **START:** `start_bit_o`=1 and both vectors = 0. The array clears its accumulators on this pulse.
- **DRAIN:** both vectors = 0 while in-flight operands propagate to the far corner.
- **Outputs:** all outputs are registered, and output values follow the current state.
- **Reset:**
  - Reset values: state IDLE, `t`=0, latched operands 0, vectors 0, `start_bit_o`=0, `busy_o`=0, `done_o`=0, `ld_ready_o`=1 once `reset_ni` is high.
  - Reset asserted mid-job: the job is abandoned, `done_o` never fires, and the outputs above take their reset values immediately (asynchronously).

## Timing
- Cycle h is the edge at which the load handshake occurs. M and N do not change latency.
  - h+1: `start_bit_o`=1, `busy_o`=1.
  - h+2+t, for t = 0..`K+MAX_DIM-2`: skewed vectors for step t.
  - h+`K+MAX_DIM`+1 .. h+`K+2*MAX_DIM`−1: DRAIN, vectors 0.
  - h+`K+2*MAX_DIM`: `done_o`=1. The PE(`MAX_DIM`−1,`MAX_DIM`−1) accumulator holds its final sum.
  - h+`K+2*MAX_DIM`+1: IDLE, `ld_ready_o`=1.
- Worked example, K=4, `MAX_DIM`=4: done at h+12; next accept earliest at h+13.
- `ld_valid_i` held high continuously: back-to-back jobs, with handshakes spaced `K+2*MAX_DIM`+1 cycles apart.
- `done_o` and `ld_ready_o` are never high in the same cycle.

## Structure
- **Shared package `matmul_pkg`:**
  - state encoding (IDLE/START/STREAM/DRAIN/DONE)
  - `MAX_DIM` and `Elements_Num` derivation
  - `CW`, and step-counter width `$clog2(3*MAX_DIM)`
- **Sub-module `matmul_skew_sel`:** purely combinational. Given lane index, `t`, K, the lane-valid flag (`r<M` or `c<N`), and the lane's latched row/column, it returns the element or 0. It is instantiated once per A lane and once per B lane.
- **Top level:** FSM, step counter, operand registers, output registers.

## Test plan
1. **Reset mid-STREAM:** assert `reset_ni`=0 at h+4 → all outputs 0 within the same cycle; `done_o` never pulses; `ld_ready_o`=1 after release.
2. **Full 4×4 job:** A = [1..16] row-major, B = identity, `k_dim_i`=3.
   - At h+2, `a_vec_o` lane0 = 1, other lanes 0; `b_vec_o` lane0 = 1.
   - At h+5, a lanes 0..3 = {4, 7, 10, 13}.
   - `done_o` at h+12; array result = A.
3. **Reduced dims:** M=2, K=3, N=1, all elements 5.
   - A lanes 2–3 and B lanes 1–3 stay 0 throughout.
   - Result C[0][0] = 75 (three products of 25).
   - `done_o` at h+11.
4. **Handshake gating:** `ld_valid_i` held high during a job with different data → ignored; the second job is accepted at h+13 with its own data.
5. **Back-to-back with K=1:** handshake spacing 10 cycles; `start_bit_o` pulses exactly once per job.
6. **Max operands:** all elements 255, K=4 → result 260100 per element; `out_of_mat`=0.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared constants, size derivations and state encoding for the systolic
// matmul feeder slice.
package matmul_pkg;

    localparam int PKG_DW = 8;
    localparam int PKG_BW = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    // The array is as wide as the number of elements that fit in one accumulator.
    function automatic int max_dim_of(input int dw, input int bw);
        return bw / dw;
    endfunction

    function automatic int elements_num_of(input int max_dim);
        return max_dim * max_dim;
    endfunction

    // Step counter must reach K+MAX_DIM-2 with K up to MAX_DIM.
    function automatic int step_width(input int max_dim);
        return $clog2(3 * max_dim);
    endfunction

endpackage

// File: rtl/matmul_skew_sel.sv
// Picks the element a single edge lane presents at a given stream step, or 0
// when the lane is outside the active diagonal window or the matrix bounds.
module matmul_skew_sel
    import matmul_pkg::*;
#(
    parameter int DW      = PKG_DW,
    parameter int MAX_DIM = max_dim_of(PKG_DW, PKG_BW),
    parameter int CW      = $clog2(MAX_DIM),
    parameter int TW      = step_width(MAX_DIM)
) (
    input  logic [CW-1:0]         lane,
    input  logic [TW-1:0]         step,
    input  logic [CW:0]           k_len,
    input  logic                  lane_valid,
    input  logic [MAX_DIM*DW-1:0] elems,
    output logic [DW-1:0]         elem
);

    logic [TW-1:0] offset_s;
    logic          in_window_s;

    // Lane l is delayed by l steps, so it shows element (step - l) of its row/column.
    always_comb begin
        offset_s    = step - TW'(lane);
        in_window_s = (step >= TW'(lane)) && (offset_s < TW'(k_len));
        if (lane_valid && in_window_s) begin
            elem = elems[offset_s[CW-1:0]*DW +: DW];
        end else begin
            elem = '0;
        end
    end

endmodule

// File: rtl/matmul_feeder.sv
// Job sequencer feeding skewed A rows and B columns into the systolic PE array;
// latches one operand pair per job and pulses done when the far corner is final.
module matmul_feeder
    import matmul_pkg::*;
#(
    parameter int DW           = PKG_DW,
    parameter int BW           = PKG_BW,
    parameter int MAX_DIM      = max_dim_of(DW, BW),
    parameter int Elements_Num = elements_num_of(MAX_DIM),
    parameter int CW           = $clog2(MAX_DIM)
) (
    input  logic                       clk_i,
    input  logic                       reset_ni,
    input  logic                       ld_valid_i,
    output logic                       ld_ready_o,
    input  logic [Elements_Num*DW-1:0] mat_a_i,
    input  logic [Elements_Num*DW-1:0] mat_b_i,
    input  logic [CW-1:0]              m_dim_i,
    input  logic [CW-1:0]              k_dim_i,
    input  logic [CW-1:0]              n_dim_i,
    output logic [MAX_DIM*DW-1:0]      a_vec_o,
    output logic [MAX_DIM*DW-1:0]      b_vec_o,
    output logic                       start_bit_o,
    output logic                       busy_o,
    output logic                       done_o
);

    localparam int TW   = step_width(MAX_DIM);
    localparam int LW   = MAX_DIM * DW;
    localparam int DIMW = CW + 1;
    // Both the stream tail and the drain length are the array's diagonal skew.
    localparam logic [TW-1:0] DIAG_TAIL = TW'(MAX_DIM - 2);

    state_e                     state_r;
    state_e                     next_state_s;
    logic [TW-1:0]              step_r;
    logic [TW-1:0]              next_step_s;
    logic [TW-1:0]              stream_last_s;
    logic [Elements_Num*DW-1:0] mat_a_r;
    logic [Elements_Num*DW-1:0] mat_b_r;
    logic [DIMW-1:0]            m_len_r;
    logic [DIMW-1:0]            k_len_r;
    logic [DIMW-1:0]            n_len_r;
    logic [LW-1:0]              a_lanes_s;
    logic [LW-1:0]              b_lanes_s;
    logic [LW-1:0]              a_vec_r;
    logic [LW-1:0]              b_vec_r;
    logic                       start_r;
    logic                       busy_r;
    logic                       done_r;
    logic                       ld_ready_r;
    logic                       accept_s;

    assign accept_s      = (state_r == ST_IDLE) && ld_valid_i;
    assign stream_last_s = TW'(k_len_r) + DIAG_TAIL;

    // Next state and step count; the step counter is reused to time the drain.
    always_comb begin
        next_state_s = state_r;
        next_step_s  = step_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    next_state_s = ST_START;
                    next_step_s  = '0;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_START: begin
                next_state_s = ST_STREAM;
                next_step_s  = '0;
            end
            ST_STREAM: begin
                if (step_r == stream_last_s) begin
                    next_state_s = ST_DRAIN;
                    next_step_s  = '0;
                end else begin
                    next_step_s = step_r + TW'(1);
                end
            end
            ST_DRAIN: begin
                if (step_r == DIAG_TAIL) begin
                    next_state_s = ST_DONE;
                    next_step_s  = '0;
                end else begin
                    next_step_s = step_r + TW'(1);
                end
            end
            ST_DONE: begin
                next_state_s = ST_IDLE;
                next_step_s  = '0;
            end
            default: begin
                next_state_s = ST_IDLE;
                next_step_s  = '0;
            end
        endcase
    end

    // One selector per A row lane and per B column lane, evaluated for the upcoming step.
    for (genvar gl = 0; gl < MAX_DIM; gl++) begin : g_lane
        logic [LW-1:0] col_s;

        for (genvar gk = 0; gk < MAX_DIM; gk++) begin : g_col
            assign col_s[gk*DW +: DW] = mat_b_r[(gk*MAX_DIM+gl)*DW +: DW];
        end

        matmul_skew_sel #(
            .DW      (DW),
            .MAX_DIM (MAX_DIM),
            .CW      (CW),
            .TW      (TW)
        ) u_a_sel (
            .lane       (CW'(gl)),
            .step       (next_step_s),
            .k_len      (k_len_r),
            .lane_valid (DIMW'(gl) < m_len_r),
            .elems      (mat_a_r[gl*LW +: LW]),
            .elem       (a_lanes_s[gl*DW +: DW])
        );

        matmul_skew_sel #(
            .DW      (DW),
            .MAX_DIM (MAX_DIM),
            .CW      (CW),
            .TW      (TW)
        ) u_b_sel (
            .lane       (CW'(gl)),
            .step       (next_step_s),
            .k_len      (k_len_r),
            .lane_valid (DIMW'(gl) < n_len_r),
            .elems      (col_s),
            .elem       (b_lanes_s[gl*DW +: DW])
        );
    end

    // FSM, operand latch and output registers; outputs are loaded from the next state.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_r    <= ST_IDLE;
            step_r     <= '0;
            mat_a_r    <= '0;
            mat_b_r    <= '0;
            m_len_r    <= '0;
            k_len_r    <= '0;
            n_len_r    <= '0;
            a_vec_r    <= '0;
            b_vec_r    <= '0;
            start_r    <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            ld_ready_r <= 1'b1;
        end else begin
            state_r <= next_state_s;
            step_r  <= next_step_s;
            if (accept_s) begin
                mat_a_r <= mat_a_i;
                mat_b_r <= mat_b_i;
                m_len_r <= {1'b0, m_dim_i} + DIMW'(1);
                k_len_r <= {1'b0, k_dim_i} + DIMW'(1);
                n_len_r <= {1'b0, n_dim_i} + DIMW'(1);
            end
            start_r    <= (next_state_s == ST_START);
            busy_r     <= (next_state_s != ST_IDLE);
            done_r     <= (next_state_s == ST_DONE);
            ld_ready_r <= (next_state_s == ST_IDLE);
            a_vec_r    <= (next_state_s == ST_STREAM) ? a_lanes_s : '0;
            b_vec_r    <= (next_state_s == ST_STREAM) ? b_lanes_s : '0;
        end
    end

    // No job can be accepted while reset is held.
    assign ld_ready_o  = ld_ready_r & reset_ni;
    assign a_vec_o     = a_vec_r;
    assign b_vec_o     = b_vec_r;
    assign start_bit_o = start_r;
    assign busy_o      = busy_r;
    assign done_o      = done_r;

endmodule

// File: tb/tb_matmul_feeder.sv
// Scoreboarded bench for matmul_feeder: a matrix-level model predicts every
// output cycle of each job and the product the PE array would accumulate.
`timescale 1ns/1ps
module tb_matmul_feeder;
    import matmul_pkg::*;

    localparam int DW = 8;
    localparam int MD = 4;
    localparam int EN = MD * MD;
    localparam int CW = 2;
    localparam int LW = MD * DW;
    localparam int NS = 3 * MD;

    logic           clk = 1'b0;
    logic           reset_ni = 1'b0;
    logic           ld_valid = 1'b0;
    logic           ld_ready;
    logic [EN*DW-1:0] mat_a = '0;
    logic [EN*DW-1:0] mat_b = '0;
    logic [CW-1:0]  m_dim = '0;
    logic [CW-1:0]  k_dim = '0;
    logic [CW-1:0]  n_dim = '0;
    logic [LW-1:0]  a_vec;
    logic [LW-1:0]  b_vec;
    logic           start_bit;
    logic           busy;
    logic           done;

    always #5 clk = ~clk;

    matmul_feeder dut (
        .clk_i       (clk),
        .reset_ni    (reset_ni),
        .ld_valid_i  (ld_valid),
        .ld_ready_o  (ld_ready),
        .mat_a_i     (mat_a),
        .mat_b_i     (mat_b),
        .m_dim_i     (m_dim),
        .k_dim_i     (k_dim),
        .n_dim_i     (n_dim),
        .a_vec_o     (a_vec),
        .b_vec_o     (b_vec),
        .start_bit_o (start_bit),
        .busy_o      (busy),
        .done_o      (done)
    );

    typedef struct {
        logic [LW-1:0] ea;
        logic [LW-1:0] eb;
        logic          est;
        logic          edn;
        int            step;
    } exp_t;

    exp_t                 exp_q[$];
    logic [EN*32-1:0]     exp_c_q[$];
    int                   n_cmp = 0;
    int                   n_err = 0;
    int                   cyc = 0;
    int                   last_hs = 0;
    int                   last_k = 0;

    // Current job, in matrix terms (dimensions already decoded to 1..MD).
    int ja[MD][MD];
    int jb[MD][MD];
    int jm, jk, jn;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic set_inputs();
        for (int r = 0; r < MD; r++) begin
            for (int c = 0; c < MD; c++) begin
                mat_a[(r*MD+c)*DW +: DW] = 8'(ja[r][c]);
                mat_b[(r*MD+c)*DW +: DW] = 8'(jb[r][c]);
            end
        end
        m_dim = CW'(jm - 1);
        k_dim = CW'(jk - 1);
        n_dim = CW'(jn - 1);
    endtask

    // Model: one start cycle, skewed stream, drain, done; plus the plain product A*B.
    task automatic push_expect();
        exp_t e;
        logic [EN*32-1:0] cexp;
        int kk;
        int sum;
        e.ea = '0; e.eb = '0; e.est = 1'b1; e.edn = 1'b0; e.step = -1;
        exp_q.push_back(e);
        e.est = 1'b0;
        for (int t = 0; t <= jk + MD - 2; t++) begin
            e.ea = '0; e.eb = '0; e.step = t;
            for (int l = 0; l < MD; l++) begin
                kk = t - l;
                if (kk >= 0 && kk < jk) begin
                    if (l < jm) e.ea[l*DW +: DW] = 8'(ja[l][kk]);
                    if (l < jn) e.eb[l*DW +: DW] = 8'(jb[kk][l]);
                end
            end
            exp_q.push_back(e);
        end
        e.ea = '0; e.eb = '0; e.step = -1;
        for (int d = 0; d < MD - 1; d++) exp_q.push_back(e);
        e.edn = 1'b1;
        exp_q.push_back(e);
        cexp = '0;
        for (int r = 0; r < MD; r++) begin
            for (int c = 0; c < MD; c++) begin
                sum = 0;
                if (r < jm && c < jn) begin
                    for (int k = 0; k < jk; k++) sum += ja[r][k] * jb[k][c];
                end
                cexp[(r*MD+c)*32 +: 32] = 32'(sum);
            end
        end
        exp_c_q.push_back(cexp);
    endtask

    // Present the current job and wait (bounded) for the feeder to take it.
    task automatic issue(input bit chk_gap);
        int w;
        int hs;
        set_inputs();
        ld_valid = 1'b1;
        w = 0;
        while (!ld_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!ld_ready) begin
            n_cmp++; n_err++;
            $display("FAIL accept_timeout: ld_ready still %b after %0d cycles, required 1", ld_ready, w);
        end else begin
            push_expect();
            hs = cyc + 1;
            if (chk_gap) begin
                n_cmp++;
                if (hs - last_hs != last_k + 2*MD + 1) begin
                    n_err++;
                    $display("FAIL hs_spacing: got %0d cycles, required %0d", hs - last_hs, last_k + 2*MD + 1);
                end
            end
            last_hs = hs;
            last_k  = jk;
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic rand_job(input int m, input int k, input int n);
        for (int r = 0; r < MD; r++) begin
            for (int c = 0; c < MD; c++) begin
                ja[r][c] = int'($urandom_range(0, 255));
                jb[r][c] = int'($urandom_range(0, 255));
            end
        end
        jm = m; jk = k; jn = n;
    endtask

    task automatic fill_job(input int av, input int bv, input int m, input int k, input int n);
        for (int r = 0; r < MD; r++) begin
            for (int c = 0; c < MD; c++) begin
                ja[r][c] = av;
                jb[r][c] = bv;
            end
        end
        jm = m; jk = k; jn = n;
    endtask

    task automatic check_in_reset(input string name);
        n_cmp++;
        if ({a_vec, b_vec, start_bit, busy, done, ld_ready} !== '0) begin
            n_err++;
            $display("FAIL %s: a=%h b=%h st=%b busy=%b done=%b rdy=%b, required all 0",
                     name, a_vec, b_vec, start_bit, busy, done, ld_ready);
        end
    endtask

    // Monitor: pops one expected record per busy cycle, otherwise expects an idle feeder.
    exp_t             m_e;
    logic [LW-1:0]    obs_a[NS];
    logic [LW-1:0]    obs_b[NS];
    logic [EN*32-1:0] m_cexp;
    int               m_sum;
    int               m_v;
    int               m_bad;

    always begin
        @(posedge clk);
        #1;
        if (reset_ni) begin
            n_cmp++;
            if (exp_q.size() > 0) begin
                m_e = exp_q.pop_front();
                if ({a_vec, b_vec, start_bit, busy, done, ld_ready} !== {m_e.ea, m_e.eb, m_e.est, 1'b1, m_e.edn, 1'b0}) begin
                    n_err++;
                    $display("FAIL job_cycle @%0d step=%0d: a=%h b=%h st/busy/done/rdy=%b%b%b%b, required a=%h b=%h %b1%b0",
                             cyc, m_e.step, a_vec, b_vec, start_bit, busy, done, ld_ready,
                             m_e.ea, m_e.eb, m_e.est, m_e.edn);
                end
                if (m_e.est) begin
                    for (int i = 0; i < NS; i++) begin
                        obs_a[i] = '0;
                        obs_b[i] = '0;
                    end
                end
                if (m_e.step >= 0) begin
                    obs_a[m_e.step] = a_vec;
                    obs_b[m_e.step] = b_vec;
                end
                if (m_e.edn && exp_c_q.size() > 0) begin
                    // PE(r,c) sees row r delayed by c and column c delayed by r.
                    m_cexp = exp_c_q.pop_front();
                    m_bad = -1;
                    for (int r = 0; r < MD; r++) begin
                        for (int c = 0; c < MD; c++) begin
                            m_sum = 0;
                            for (int u = 0; u < NS; u++) begin
                                m_v = u + c - r;
                                if (m_v >= 0 && m_v < NS)
                                    m_sum += int'(obs_a[u][r*DW +: DW]) * int'(obs_b[m_v][c*DW +: DW]);
                            end
                            if (32'(m_sum) != m_cexp[(r*MD+c)*32 +: 32] && m_bad < 0) begin
                                m_bad = r*MD + c;
                                $display("FAIL result C[%0d][%0d]: got %0d, required %0d",
                                         r, c, m_sum, m_cexp[(r*MD+c)*32 +: 32]);
                            end
                        end
                    end
                    n_cmp++;
                    if (m_bad >= 0) n_err++;
                end
            end else begin
                if ({a_vec, b_vec, start_bit, busy, done, ld_ready} !== {{(2*LW){1'b0}}, 4'b0001}) begin
                    n_err++;
                    $display("FAIL idle @%0d: a=%h b=%h st/busy/done/rdy=%b%b%b%b, required 0 0 0001",
                             cyc, a_vec, b_vec, start_bit, busy, done, ld_ready);
                end
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check_in_reset("reset_hold");
        reset_ni = 1'b1;
        #1;
        n_cmp++;
        if (ld_ready !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL ready_after_reset: rdy=%b busy=%b, required 1 0", ld_ready, busy);
        end
        @(negedge clk);

        // Reset in the middle of the stream abandons the job.
        rand_job(4, 3, 4);
        for (int r = 0; r < MD; r++) ja[r][0] = 200 + r;
        issue(1'b0);
        ld_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset_ni = 1'b0;
        #1;
        check_in_reset("reset_mid_stream");
        exp_q.delete();
        exp_c_q.delete();
        repeat (2) @(negedge clk);
        reset_ni = 1'b1;
        #1;
        n_cmp++;
        if (ld_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL ready_after_abort: rdy=%b busy=%b done=%b, required 1 0 0", ld_ready, busy, done);
        end
        repeat (4) @(negedge clk);

        // Full 4x4, A = 1..16, B = identity.
        for (int r = 0; r < MD; r++) begin
            for (int c = 0; c < MD; c++) begin
                ja[r][c] = r*MD + c + 1;
                jb[r][c] = (r == c) ? 1 : 0;
            end
        end
        jm = 4; jk = 4; jn = 4;
        issue(1'b0);
        ld_valid = 1'b0;
        repeat (2) @(negedge clk);

        // Reduced dimensions with constant data.
        fill_job(5, 5, 2, 3, 1);
        issue(1'b0);
        ld_valid = 1'b0;
        repeat (3) @(negedge clk);

        // Valid held with new data while busy: only the second presentation counts.
        rand_job(3, 4, 2);
        issue(1'b0);
        rand_job(4, 2, 3);
        issue(1'b1);
        ld_valid = 1'b0;
        repeat (2) @(negedge clk);

        // Back-to-back K=1 jobs.
        rand_job(4, 1, 4);
        issue(1'b0);
        for (int j = 0; j < 3; j++) begin
            rand_job(int'($urandom_range(1, 4)), 1, int'($urandom_range(1, 4)));
            issue(1'b1);
        end
        ld_valid = 1'b0;
        repeat (1) @(negedge clk);

        // Largest operands.
        fill_job(255, 255, 4, 4, 4);
        issue(1'b0);
        ld_valid = 1'b0;

        // Random jobs with random gaps.
        for (int j = 0; j < 8; j++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            rand_job(int'($urandom_range(1, 4)), int'($urandom_range(1, 4)), int'($urandom_range(1, 4)));
            issue(1'b0);
            ld_valid = 1'($urandom_range(0, 1));
            if (ld_valid) begin
                rand_job(int'($urandom_range(1, 4)), int'($urandom_range(1, 4)), int'($urandom_range(1, 4)));
                issue(1'b1);
                ld_valid = 1'b0;
            end
        end

        for (int w = 0; w < 100 && exp_q.size() > 0; w++) @(negedge clk);
        n_cmp++;
        if (exp_q.size() > 0) begin
            n_err++;
            $display("FAIL drain_timeout: %0d expected cycles still pending, required 0", exp_q.size());
        end
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
